pixel_mixer_nlayer: RTL and testbench

Parametrised next-generation pixel mixer. It merges NUM_TILE_LAYERS tile layers and one sprite layer into the final rowbuffer, one pixel per cycle. It sits between the pixel engines (tile engines and the sprite engine) and the final row RAM. Over the 3-layer mixer it adds the following:
- configurable layer count, row width and engine read latency;
- per-layer enable mask;
- done pulses that arrive during a row are kept for the next row;
- registered outputs and a row-complete pulse.

---
 rtl/pixel_mixer_nlayer.sv | 182 ++++++++++++++++++
 tb/tb_pixel_mixer_nlayer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_mixer_nlayer.sv
// Pixel mixer: merges NUM_TILE_LAYERS tile layers and one sprite layer into
// the final rowbuffer, one pixel per cycle, with a registered write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_WAIT  | idle; waiting for every engine's done record to be set
// S_FETCH | issuing pixel_addr 0..ROW_WIDTH-1, one per cycle
// S_DRAIN | no new requests; waiting for the last write to leave
module pixel_mixer_nlayer #(
  parameter int NUM_TILE_LAYERS = 2,
  parameter int ROW_WIDTH       = 320,
  parameter int ADDR_W          = 9,
  parameter int COLOR_W         = 4,
  parameter int PAL_W           = 4,
  parameter int LAYER_W         = (NUM_TILE_LAYERS > 1) ? $clog2(NUM_TILE_LAYERS) : 1,
  parameter int SP_PAL_W        = PAL_W + LAYER_W,
  parameter int PRIO_W          = $clog2(NUM_TILE_LAYERS + 1),
  parameter int READ_LATENCY    = 1,
  parameter int OUT_W           = 1 + SP_PAL_W + COLOR_W
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NUM_TILE_LAYERS:0]                 layer_en,
  output logic [ADDR_W-1:0]                        pixel_addr,
  output logic                                     pixel_rd,
  input  logic [NUM_TILE_LAYERS*(PAL_W+COLOR_W)-1:0] tile_pixel_data,
  input  logic [SP_PAL_W+COLOR_W-1:0]              sp_pixel_data,
  input  logic [PRIO_W-1:0]                        sp_pixel_prio,
  input  logic [NUM_TILE_LAYERS-1:0]               tile_done,
  input  logic                                     spre_done,
  output logic [OUT_W-1:0]                         pmxr_rowram_wrdata,
  output logic [ADDR_W-1:0]                        pmxr_rowram_wraddr,
  output logic                                     pmxr_rowram_wren,
  output logic                                     row_done,
  output logic                                     busy
);

  localparam int TILE_W = PAL_W + COLOR_W;
  localparam int NUM_EN = NUM_TILE_LAYERS + 1;
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(ROW_WIDTH - 1);

  typedef enum logic [1:0] {S_WAIT, S_FETCH, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_fetch;
  logic                w_busy;
  logic [ADDR_W-1:0]   r_addr;
  logic [NUM_EN-1:0]   r_done;
  logic [NUM_EN-1:0]   r_mask;
  logic [NUM_EN-1:0]   w_done_pulse;
  logic [NUM_EN-1:0]   w_done_set;
  logic                w_start;
  logic                w_last_write;
  logic [READ_LATENCY-1:0] r_vld_pipe;
  logic [ADDR_W-1:0]   r_addr_pipe [READ_LATENCY];
  logic [TILE_W-1:0]   w_tile [NUM_TILE_LAYERS];
  logic                w_sp_opaque;
  logic [OUT_W-1:0]    w_mix;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_wraddr;
  logic [OUT_W-1:0]    r_wrdata;
  logic                r_row_done;

  // Pulses are folded into the records combinationally so a row can start
  // in the same cycle the last pulse arrives.
  assign w_done_pulse = {spre_done, tile_done};
  assign w_done_set   = r_done | w_done_pulse;
  assign w_start      = (r_state == S_WAIT) && (&w_done_set);
  assign w_last_write = r_wren && (r_wraddr == LAST_COL);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_fetch     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (w_start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_fetch = 1'b1;
        w_busy  = 1'b1;
        if (r_addr == LAST_COL) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_last_write) w_state_nxt = S_WAIT;
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Column counter; wraps to 0 on the last fetch so it idles at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_fetch) begin
      r_addr <= (r_addr == LAST_COL) ? '0 : r_addr + 1'b1;
    end
  end

  // Done records (set wins over the start-of-row clear) and row mask capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= '0;
      r_mask <= '0;
    end else if (w_start) begin
      r_done <= w_done_pulse;
      r_mask <= layer_en;
    end else begin
      r_done <= w_done_set;
    end
  end

  // Valid/address delay line matching the engine read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_addr_pipe[i] <= '0;
    end else begin
      r_vld_pipe[0]  <= w_fetch;
      r_addr_pipe[0] <= r_addr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
    end
  end

  // Split the packed tile bus into per-layer {palette, color} words
  always_comb begin
    for (int i = 0; i < NUM_TILE_LAYERS; i++) begin
      w_tile[i] = tile_pixel_data[i*TILE_W +: TILE_W];
    end
  end

  assign w_sp_opaque = (sp_pixel_data[COLOR_W-1:0] != '0) && r_mask[NUM_TILE_LAYERS];

  // Walk layers back to front; each opaque layer overwrites what is behind it.
  // The sprite is considered just before tile layer p, or after all of them.
  always_comb begin
    w_mix = '0;
    for (int i = 0; i < NUM_TILE_LAYERS; i++) begin
      if (w_sp_opaque && (32'(sp_pixel_prio) == i)) w_mix = {1'b1, sp_pixel_data};
      if ((w_tile[i][COLOR_W-1:0] != '0) && r_mask[i]) w_mix = {1'b0, LAYER_W'(i), w_tile[i]};
    end
    if (w_sp_opaque && (32'(sp_pixel_prio) >= NUM_TILE_LAYERS)) w_mix = {1'b1, sp_pixel_data};
  end

  // Registered write port; data/address hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wren     <= 1'b0;
      r_wraddr   <= '0;
      r_wrdata   <= '0;
      r_row_done <= 1'b0;
    end else begin
      r_wren     <= r_vld_pipe[READ_LATENCY-1];
      r_row_done <= w_last_write;
      if (r_vld_pipe[READ_LATENCY-1]) begin
        r_wraddr <= r_addr_pipe[READ_LATENCY-1];
        r_wrdata <= w_mix;
      end
    end
  end

  assign pixel_addr         = w_fetch ? r_addr : '0;
  assign pixel_rd           = w_fetch;
  assign busy               = w_busy;
  assign pmxr_rowram_wren   = r_wren;
  assign pmxr_rowram_wraddr = r_wraddr;
  assign pmxr_rowram_wrdata = r_wrdata;
  assign row_done           = r_row_done;

endmodule

// File: tb/tb_pixel_mixer_nlayer.sv
// Testbench for pixel_mixer_nlayer: a default build (A) and a 4-layer,
// 16-pixel, latency-3 build (B), each with an engine model and a scoreboard.
module tb_pixel_mixer_nlayer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  // ---------------- build A (defaults) ----------------
  logic [2:0]  a_en;
  logic [8:0]  a_paddr;
  logic        a_prd;
  logic [15:0] a_tile;
  logic [8:0]  a_sp;
  logic [1:0]  a_prio;
  logic [1:0]  a_tdone;
  logic        a_sdone;
  logic [9:0]  a_wrdata;
  logic [8:0]  a_wraddr;
  logic        a_wren, a_rowdone, a_busy;

  pixel_mixer_nlayer u_a (
    .clk(clk), .rst_n(rst_n), .layer_en(a_en),
    .pixel_addr(a_paddr), .pixel_rd(a_prd),
    .tile_pixel_data(a_tile), .sp_pixel_data(a_sp), .sp_pixel_prio(a_prio),
    .tile_done(a_tdone), .spre_done(a_sdone),
    .pmxr_rowram_wrdata(a_wrdata), .pmxr_rowram_wraddr(a_wraddr),
    .pmxr_rowram_wren(a_wren), .row_done(a_rowdone), .busy(a_busy)
  );

  // Directed vectors for A, used at columns 0..7 and 312..319
  localparam logic [7:0] VA_T0 [8] = '{8'h35, 8'h35, 8'h35, 8'h35, 8'h30, 8'h30, 8'h30, 8'h3F};
  localparam logic [7:0] VA_T1 [8] = '{8'h72, 8'h70, 8'h72, 8'h70, 8'h70, 8'h72, 8'h70, 8'h4E};
  localparam logic [8:0] VA_SP [8] = '{9'h1A9, 9'h1A9, 9'h1A9, 9'h1A9, 9'h1A0, 9'h1A9, 9'h0A5, 9'h1A9};
  localparam logic [1:0] VA_PR [8] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  localparam logic [9:0] EA_111 [8] = '{10'h172, 10'h035, 10'h3A9, 10'h3A9, 10'h000, 10'h3A9, 10'h2A5, 10'h14E};
  localparam logic [9:0] EA_101 [8] = '{10'h035, 10'h035, 10'h3A9, 10'h3A9, 10'h000, 10'h3A9, 10'h2A5, 10'h3A9};
  localparam logic [9:0] EA_010 [8] = '{10'h172, 10'h000, 10'h172, 10'h000, 10'h000, 10'h172, 10'h000, 10'h14E};

  function automatic int vidx_a(input logic [8:0] c);
    if (c < 9'd8) return int'(c);
    if (c >= 9'd312 && c < 9'd320) return int'(c) - 312;
    return -1;
  endfunction

  logic [8:0] a_d1;
  int a_k;
  always @(posedge clk) a_d1 <= a_paddr;
  assign a_k = vidx_a(a_d1);

  // Engine model A: one cycle read latency
  always_comb begin
    a_tile = '0;
    a_sp   = '0;
    a_prio = '0;
    if (a_k >= 0) begin
      a_tile = {VA_T1[a_k], VA_T0[a_k]};
      a_sp   = VA_SP[a_k];
      a_prio = VA_PR[a_k];
    end
  end

  // ---------------- build B (4 layers, 16 px, latency 3) ----------------
  logic [4:0]  b_en;
  logic [3:0]  b_paddr;
  logic        b_prd;
  logic [31:0] b_tile;
  logic [9:0]  b_sp;
  logic [2:0]  b_prio;
  logic [3:0]  b_tdone;
  logic        b_sdone;
  logic [10:0] b_wrdata;
  logic [3:0]  b_wraddr;
  logic        b_wren, b_rowdone, b_busy;

  pixel_mixer_nlayer #(
    .NUM_TILE_LAYERS(4), .ROW_WIDTH(16), .ADDR_W(4), .READ_LATENCY(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .layer_en(b_en),
    .pixel_addr(b_paddr), .pixel_rd(b_prd),
    .tile_pixel_data(b_tile), .sp_pixel_data(b_sp), .sp_pixel_prio(b_prio),
    .tile_done(b_tdone), .spre_done(b_sdone),
    .pmxr_rowram_wrdata(b_wrdata), .pmxr_rowram_wraddr(b_wraddr),
    .pmxr_rowram_wren(b_wren), .row_done(b_rowdone), .busy(b_busy)
  );

  localparam logic [31:0] VB_T  [8] = '{32'h44332211, 32'h40332211, 32'h40302211, 32'h4C302211,
                                        32'h40302010, 32'h40302011, 32'h40302010, 32'h44332211};
  localparam logic [9:0]  VB_SP [8] = '{10'h3F5, 10'h3F5, 10'h3F5, 10'h3F5, 10'h3F0, 10'h3F5, 10'h125, 10'h3F5};
  localparam logic [2:0]  VB_PR [8] = '{3'd4, 3'd2, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd7};
  localparam logic [10:0] EB    [8] = '{11'h7F5, 11'h233, 11'h7F5, 11'h34C, 11'h000, 11'h011, 11'h525, 11'h7F5};

  logic [3:0] b_d1, b_d2, b_d3;
  always @(posedge clk) begin
    b_d1 <= b_paddr;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end

  // Engine model B: three cycle read latency
  always_comb begin
    b_tile = '0;
    b_sp   = '0;
    b_prio = '0;
    if (b_d3 < 4'd8) begin
      b_tile = VB_T[b_d3[2:0]];
      b_sp   = VB_SP[b_d3[2:0]];
      b_prio = VB_PR[b_d3[2:0]];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int a_wr_cnt = 0;
  int b_wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_row_a(input int m);
    logic [9:0] e;
    int k;
    for (int c = 0; c < 320; c++) begin
      k = vidx_a(9'(c));
      e = '0;
      if (k >= 0) e = (m == 0) ? EA_111[k] : (m == 1) ? EA_101[k] : EA_010[k];
      qa.push_back({16'(c), 6'd0, e});
    end
  endtask

  task automatic push_row_b();
    for (int c = 0; c < 16; c++) begin
      qb.push_back({16'(c), 5'd0, (c < 8) ? EB[c] : 11'h000});
    end
  endtask

  // Monitor A
  initial begin
    logic       pw;
    logic [8:0] pa;
    logic [31:0] e;
    pw = 1'b0;
    pa = '0;
    forever begin
      @(posedge clk);
      #1;
      if (a_wren) begin
        a_wr_cnt++;
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_unexpected_write: got write at addr %0d want none", a_wraddr);
        end else begin
          e = qa.pop_front();
          chk("a_wraddr", 32'(a_wraddr), 32'(e[31:16]));
          chk("a_wrdata", 32'(a_wrdata), 32'(e[15:0]));
        end
      end
      if (a_rowdone) chk("a_rowdone_after_last", {22'd0, pw, pa}, {22'd0, 1'b1, 9'd319});
      pw = a_wren;
      pa = a_wraddr;
    end
  end

  // Monitor B
  initial begin
    logic       pw;
    logic [3:0] pa;
    logic [31:0] e;
    pw = 1'b0;
    pa = '0;
    forever begin
      @(posedge clk);
      #1;
      if (b_wren) begin
        b_wr_cnt++;
        if (qb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_unexpected_write: got write at addr %0d want none", b_wraddr);
        end else begin
          e = qb.pop_front();
          chk("b_wraddr", 32'(b_wraddr), 32'(e[31:16]));
          chk("b_wrdata", 32'(b_wrdata), 32'(e[15:0]));
        end
      end
      if (b_rowdone) chk("b_rowdone_after_last", {27'd0, pw, pa}, {27'd0, 1'b1, 4'd15});
      pw = b_wren;
      pa = b_wraddr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_a(input logic [1:0] t, input logic s);
    a_tdone = t;
    a_sdone = s;
    tick(1);
    a_tdone = '0;
    a_sdone = 1'b0;
  endtask

  // 0: A row_done, 1: A write at column 100, 2: B write, 3: B row_done
  task automatic wait_sig(input int which, input int budget, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick(1);
      case (which)
        0: hit = a_rowdone;
        1: hit = a_wren && (a_wraddr == 9'd100);
        2: hit = b_wren;
        default: hit = b_rowdone;
      endcase
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: got timeout after %0d cycles want event", name, budget);
    end
  endtask

  initial begin
    int t0;
    int w0;
    a_en = 3'b111; a_tdone = '0; a_sdone = 1'b0;
    b_en = 5'h1F;  b_tdone = '0; b_sdone = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk("rst_wren", 32'(a_wren), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_prd", 32'(a_prd), 0);
    chk("rst_paddr", 32'(a_paddr), 0);
    chk("rst_wrdata", 32'(a_wrdata), 0);
    chk("rst_wraddr", 32'(a_wraddr), 0);
    chk("rst_rowdone", 32'(a_rowdone), 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_no_done", 32'(a_busy), 0);

    // Full row, all dones in the same cycle
    push_row_a(0);
    pulse_a(2'b11, 1'b1);
    chk("t1_busy", 32'(a_busy), 1);
    chk("t1_prd", 32'(a_prd), 1);
    chk("t1_paddr0", 32'(a_paddr), 0);
    t0 = cyc;
    w0 = a_wr_cnt;
    tick(1);
    chk("t1_paddr1", 32'(a_paddr), 1);
    wait_sig(0, 400, "t1_rowdone_wait");
    chk("t1_latency", 32'(cyc - t0), 322);
    chk("t1_writes", 32'(a_wr_cnt - w0), 320);
    chk("t1_wait_state", 32'(a_busy), 0);
    // The pulses of the start cycle survived the clear, so the next row starts
    tick(1);
    chk("t1_auto_restart", 32'(a_busy), 1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Staggered dones
    pulse_a(2'b01, 1'b0);
    tick(14);
    chk("t2_wait_after_t0", 32'(a_busy), 0);
    pulse_a(2'b00, 1'b1);
    tick(19);
    chk("t2_wait_after_sp", 32'(a_busy), 0);
    push_row_a(0);
    pulse_a(2'b10, 1'b0);
    chk("t2_start", 32'(a_busy), 1);
    t0 = cyc;
    tick(100);
    pulse_a(2'b00, 1'b1);
    wait_sig(0, 400, "t2_rowdone_wait");
    chk("t2_latency", 32'(cyc - t0), 322);
    tick(3);
    chk("t2_waits_tile0", 32'(a_busy), 0);

    // Enable mask 101; mid-row mask change must not apply
    push_row_a(1);
    a_en = 3'b101;
    pulse_a(2'b11, 1'b0);
    chk("t4_start_kept_sp", 32'(a_busy), 1);
    tick(50);
    a_en = 3'b010;
    wait_sig(0, 400, "t4_rowdone_wait");
    tick(2);
    chk("t4_waits_sprite", 32'(a_busy), 0);
    push_row_a(2);
    pulse_a(2'b00, 1'b1);
    chk("t4b_start", 32'(a_busy), 1);
    wait_sig(0, 400, "t4b_rowdone_wait");

    // Reset mid-row
    a_en = 3'b111;
    push_row_a(0);
    pulse_a(2'b11, 1'b0);
    chk("t6_start", 32'(a_busy), 1);
    tick(20);
    pulse_a(2'b00, 1'b1);
    wait_sig(1, 200, "t6_addr100_wait");
    rst_n = 1'b0;
    #1;
    chk("t6_abort_wren", 32'(a_wren), 0);
    chk("t6_abort_busy", 32'(a_busy), 0);
    chk("t6_abort_prd", 32'(a_prd), 0);
    qa.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("t6_no_writes_after_reset", 32'(qa.size()), 0);
    pulse_a(2'b11, 1'b0);
    tick(3);
    chk("t6_done_cleared", 32'(a_busy), 0);
    push_row_a(0);
    pulse_a(2'b00, 1'b1);
    chk("t6_restart", 32'(a_busy), 1);
    t0 = cyc;
    w0 = a_wr_cnt;
    wait_sig(0, 400, "t6_rowdone_wait");
    chk("t6_latency", 32'(cyc - t0), 322);
    chk("t6_writes", 32'(a_wr_cnt - w0), 320);

    // Parametrised build B
    push_row_b();
    b_tdone = 4'hF;
    b_sdone = 1'b1;
    tick(1);
    b_tdone = '0;
    b_sdone = 1'b0;
    chk("b_busy", 32'(b_busy), 1);
    chk("b_paddr0", 32'(b_paddr), 0);
    t0 = cyc;
    wait_sig(2, 10, "b_first_write_wait");
    chk("b_first_write_lat", 32'(cyc - t0), 4);
    wait_sig(3, 40, "b_rowdone_wait");
    chk("b_latency", 32'(cyc - t0), 20);
    chk("b_writes", 32'(b_wr_cnt), 16);

    tick(2);
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qb_empty", 32'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
